// File: rtl/voltmeter_pkg.sv
// rtl/voltmeter_pkg.sv - shared constants, state encoding and helpers for the voltmeter display path
package voltmeter_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int MAX_MV     = 9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - double-dabble correction: add 3 to a BCD nibble that is 5 or more
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A nibble >= 5 would exceed 9 after the next doubling, so pre-correct it.
  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - sequential shift-add-3 binary to packed BCD converter with saturation
module bin2bcd_serial
  import voltmeter_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = BCD_DIGITS,
  parameter int MAX_VAL   = MAX_MV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_word
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = clog2(BIN_WIDTH + 1);
  localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VAL);
  localparam logic [CW-1:0]        CNT_LOAD = CW'(BIN_WIDTH);

  state_t                state, state_next;
  logic [BIN_WIDTH-1:0]  shift_q;
  logic [W-1:0]          scratch_q;
  logic [W-1:0]          scratch_adj;
  logic [CW-1:0]         count_q;
  logic                  ovf_next_q;
  logic                  accept;
  logic                  in_over;

  // DONE can take a new start so conversions may run back to back.
  assign accept  = start && (state != ST_SHIFT);
  assign in_over = (bin_in > MAX_BIN);

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_digit u_add3 (
        .din  (scratch_q[4*g +: 4]),
        .dout (scratch_adj[4*g +: 4])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: SHIFT runs until the counter's last step.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: state_next = accept ? ST_SHIFT : ST_IDLE;
      ST_SHIFT:         state_next = (count_q == CW'(1)) ? ST_DONE : ST_SHIFT;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Datapath: load saturated input on accept, otherwise correct-and-shift while in SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      count_q    <= '0;
      ovf_next_q <= 1'b0;
    end else if (accept) begin
      shift_q    <= in_over ? MAX_BIN : bin_in;
      scratch_q  <= '0;
      count_q    <= CNT_LOAD;
      ovf_next_q <= in_over;
    end else if (state == ST_SHIFT) begin
      {scratch_q, shift_q} <= {scratch_adj[W-2:0], shift_q, 1'b0};
      count_q              <= count_q - CW'(1);
    end
  end

  // Registered outputs; result words only move together with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_word <= '0;
    end else begin
      busy <= (state_next == ST_SHIFT);
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        bcd_word <= scratch_q;
        overflow <= ovf_next_q;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// tb/tb_bin2bcd_serial.sv - randomized self-checking bench for bin2bcd_serial
module tb_bin2bcd_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd_word;

  int checks;
  int errors;

  bin2bcd_serial dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd_word (bcd_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of the saturated value, packed 4 bits per digit.
  function automatic logic [15:0] ref_bcd(input int v);
    int m;
    logic [15:0] r;
    m = (v > 9999) ? 9999 : v;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // One isolated conversion; checks latency, busy span, result and output stability.
  task automatic convert(input int v, input bit verbose);
    int lat;
    int busy_cnt;
    bit moved;
    logic [15:0] prev;
    @(negedge clk);
    prev   = bcd_word;
    start  = 1'b1;
    bin_in = 14'(v);
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    moved    = 1'b0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (bcd_word !== prev) moved = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 15);
    check("bcd_word", {16'h0, bcd_word}, {16'h0, ref_bcd(v)});
    check("overflow", {31'h0, overflow}, {31'h0, (v > 9999)});
    if (verbose) begin
      check("busy_cycles", busy_cnt, 14);
      check("stable_mid", {31'h0, moved}, 32'h0);
      check("busy_at_done", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'h0, done}, 32'h0);
    end
  endtask

  initial begin
    int vals[48];
    int seen;
    int dcnt;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'h0);
    check("rst_bcd", {16'h0, bcd_word}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    convert(0, 1'b1);
    convert(1234, 1'b1);
    convert(9999, 1'b1);
    convert(12000, 1'b1);
    convert(10000, 1'b1);
    convert(16383, 1'b1);

    // start held high with bin_in changing every cycle: accepts land 15 edges apart.
    @(negedge clk);
    dcnt = 0;
    for (int c = 0; c < 48; c++) begin
      if (c > 0) @(negedge clk);
      start   = 1'b1;
      vals[c] = int'($urandom_range(0, 16383));
      bin_in  = 14'(vals[c]);
      @(posedge clk);
      #1;
      if (done) begin
        seen = c;
        check("b2b_when", seen, 15 * (dcnt + 1));
        if (seen >= 15)
          check("b2b_bcd", {16'h0, bcd_word}, {16'h0, ref_bcd(vals[seen - 15])});
        dcnt++;
      end
    end
    check("b2b_count", dcnt, 3);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);

    // Reset in the middle of SHIFT aborts with no done pulse.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd4321;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_bcd", {16'h0, bcd_word}, 32'h0);
    check("abort_ovf", {31'h0, overflow}, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    convert(42, 1'b1);
    check("after_abort", {16'h0, bcd_word}, 32'h0042);

    for (int i = 0; i < 1000; i++) begin
      convert(int'($urandom_range(0, 16383)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
